// File: rtl/cross_bar_pkg.sv
// Shared types for the 4x4 cross_bar: port counts, arbiter states, master index.
package cross_bar_pkg;

    localparam int N_MASTERS    = 4;
    localparam int N_SLAVES     = 4;
    localparam int MASTER_IDX_W = $clog2(N_MASTERS);

    typedef logic [MASTER_IDX_W-1:0] master_idx_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RELEASE
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set req bit at or above ptr (wrapping) wins.
// Purely combinational; no state, no backpressure.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     winner_o,
    output logic [IDX_W-1:0] winner_idx_o,
    output logic             any_req_o
);

    always_comb begin
        int  pos;
        logic found;
        winner_o     = '0;
        winner_idx_o = '0;
        found        = 1'b0;
        pos          = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr_i) + k) % N;
            if (!found && req_i[pos]) begin
                found         = 1'b1;
                winner_o[pos] = 1'b1;
                winner_idx_o  = IDX_W'(pos);
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/cross_bar_slave_arbiter.sv
// Per-slave session arbiter: round-robin grant held until done or watchdog abort.
// Grant one cycle after request; one-cycle RELEASE bubble between sessions.
module cross_bar_slave_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arb_en,
    input  logic [N_MASTERS-1:0]         req,
    input  logic                         session_with_slave_finished,
    output logic [N_MASTERS-1:0]         grant,
    output logic [$clog2(N_MASTERS)-1:0] grant_idx,
    output logic                         busy,
    output logic                         session_abort
);

    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    cross_bar_pkg::arb_state_t state_q, state_d;
    logic [N_MASTERS-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]          grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [N_MASTERS-1:0]      pick;
    logic [IDX_W-1:0]          pick_idx;
    logic                      any_req;
    logic                      timeout_hit;
    logic [IDX_W-1:0]          ptr_after_owner;

    rr_priority_picker #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i        (req),
        .ptr_i        (ptr_q),
        .winner_o     (pick),
        .winner_idx_o (pick_idx),
        .any_req_o    (any_req)
    );

    assign timeout_hit     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);
    assign ptr_after_owner = (grant_idx_q == IDX_W'(N_MASTERS - 1)) ?
                             '0 : grant_idx_q + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= cross_bar_pkg::ARB_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        ptr_d         = ptr_q;
        cnt_d         = '0;
        session_abort = 1'b0;
        unique case (state_q)
            cross_bar_pkg::ARB_IDLE,
            cross_bar_pkg::ARB_RELEASE: begin
                // Any done pulse outside BUSY is deliberately ignored here.
                grant_d = '0;
                state_d = cross_bar_pkg::ARB_IDLE;
                if (arb_en && any_req) begin
                    grant_d     = pick;
                    grant_idx_d = pick_idx;
                    state_d     = cross_bar_pkg::ARB_BUSY;
                end
            end
            cross_bar_pkg::ARB_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (session_with_slave_finished || timeout_hit) begin
                    // Done takes priority: abort only when the session did not finish.
                    session_abort = !session_with_slave_finished;
                    grant_d       = '0;
                    ptr_d         = ptr_after_owner;
                    cnt_d         = '0;
                    state_d       = cross_bar_pkg::ARB_RELEASE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = cross_bar_pkg::ARB_IDLE;
            end
        endcase
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = (state_q == cross_bar_pkg::ARB_BUSY);

endmodule

// File: tb/tb_cross_bar_slave_arbiter.sv
// Directed bench: the driver queues expected grants/releases/aborts with their cycle,
// and a negedge monitor pops and compares whenever the DUT output changes.
module tb_cross_bar_slave_arbiter;

    logic       clk;
    logic       rst_n;
    logic       arb_en;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       session_abort;

    cross_bar_slave_arbiter #(
        .N_MASTERS      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .arb_en                      (arb_en),
        .req                         (req),
        .session_with_slave_finished (done),
        .grant                       (grant),
        .grant_idx                   (grant_idx),
        .busy                        (busy),
        .session_abort               (session_abort)
    );

    typedef struct {
        logic [3:0] g;
        int         idx;
        int         cyc;
    } exp_t;

    exp_t       gnt_q[$];
    int         rel_q[$];
    int         abort_q[$];
    int         cyc;
    int         n_checks;
    int         n_fail;
    logic [3:0] prev_grant;
    logic [3:0] rr_seq[5];
    int         rr_idx[5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push_grant(input logic [3:0] g, input int idx, input int c);
        exp_t e;
        e.g = g;
        e.idx = idx;
        e.cyc = c;
        gnt_q.push_back(e);
    endtask

    // Monitor: invariants every cycle, scoreboard pops on output events.
    always @(negedge clk) begin
        if (rst_n === 1'b1 || rst_n === 1'b0) begin
            check("inv_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
            check("inv_grant_iff_busy", {31'd0, busy}, {31'd0, grant != 4'b0});
            if (busy) check("inv_idx_matches", {31'd0, grant[grant_idx]}, 32'd1);
            if (grant !== prev_grant) begin
                if (grant != 4'b0) begin
                    if (prev_grant != 4'b0)
                        check("grant_switch_without_bubble", {28'd0, grant}, 32'd0);
                    if (gnt_q.size() == 0) begin
                        check("unexpected_grant", {28'd0, grant}, 32'd0);
                    end else begin
                        exp_t e;
                        e = gnt_q.pop_front();
                        check("grant_value", {28'd0, grant}, {28'd0, e.g});
                        check("grant_idx", {30'd0, grant_idx}, e.idx);
                        check("grant_cycle", cyc, e.cyc);
                    end
                end else begin
                    if (rel_q.size() == 0)
                        check("unexpected_release", {28'd0, prev_grant}, 32'd0);
                    else
                        check("release_cycle", cyc, rel_q.pop_front());
                end
            end
            if (session_abort) begin
                if (abort_q.size() == 0)
                    check("unexpected_abort", 32'd1, 32'd0);
                else
                    check("abort_cycle", cyc, abort_q.pop_front());
            end
            prev_grant = grant;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        prev_grant = 4'b0;
        rr_seq     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_idx     = '{0, 1, 2, 3, 0};
        rst_n      = 1'b0;
        arb_en     = 1'b1;
        req        = 4'b0;
        done       = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_grant_idx", {30'd0, grant_idx}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_abort", {31'd0, session_abort}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();

        // Round-robin with all masters requesting; done 3 cycles after each grant
        req = 4'b1111;
        g = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            push_grant(rr_seq[i], rr_idx[i], g);
            wait_cyc(g + 2);
            done = 1'b1;
            if (i == 4) req = 4'b0;
            rel_q.push_back(g + 3);
            tick();
            done = 1'b0;
            g += 4;
        end
        wait_cyc(cyc + 3);

        // Single requester (pointer now 1)
        req = 4'b0100;
        g = cyc + 1;
        push_grant(4'b0100, 2, g);
        wait_cyc(g + 2);
        done = 1'b1;
        req = 4'b0;
        rel_q.push_back(g + 3);
        tick();
        done = 1'b0;
        wait_cyc(g + 6);

        // Ownership hold: master 1 keeps grant after its req drops
        req = 4'b0010;
        g = cyc + 1;
        push_grant(4'b0010, 1, g);
        wait_cyc(g + 1);
        req = 4'b1000;
        wait_cyc(g + 3);
        done = 1'b1;
        rel_q.push_back(g + 4);
        tick();
        done = 1'b0;
        push_grant(4'b1000, 3, g + 5);
        wait_cyc(g + 7);
        done = 1'b1;
        req = 4'b0;
        rel_q.push_back(g + 8);
        tick();
        done = 1'b0;
        wait_cyc(g + 11);

        // Watchdog abort on the 8th BUSY cycle
        req = 4'b0001;
        g = cyc + 1;
        push_grant(4'b0001, 0, g);
        wait_cyc(g + 7);
        abort_q.push_back(g + 7);
        req = 4'b0;
        rel_q.push_back(g + 8);
        wait_cyc(g + 11);

        // Done coincident with the timeout limit: no abort
        req = 4'b0001;
        g = cyc + 1;
        push_grant(4'b0001, 0, g);
        wait_cyc(g + 7);
        done = 1'b1;
        req = 4'b0;
        rel_q.push_back(g + 8);
        tick();
        done = 1'b0;
        wait_cyc(g + 11);

        // Enable gating
        arb_en = 1'b0;
        req = 4'b0011;
        wait_cyc(cyc + 5);
        check("en_gate_grant", {28'd0, grant}, 32'd0);
        arb_en = 1'b1;
        g = cyc + 1;
        push_grant(4'b0010, 1, g);
        wait_cyc(g + 1);
        arb_en = 1'b0;
        wait_cyc(g + 2);
        done = 1'b1;
        rel_q.push_back(g + 3);
        tick();
        done = 1'b0;
        wait_cyc(g + 8);
        check("en_quiesced_grant", {28'd0, grant}, 32'd0);
        check("en_quiesced_busy", {31'd0, busy}, 32'd0);
        arb_en = 1'b1;
        g = cyc + 1;
        push_grant(4'b0001, 0, g);
        wait_cyc(g + 2);
        done = 1'b1;
        req = 4'b0;
        rel_q.push_back(g + 3);
        tick();
        done = 1'b0;
        wait_cyc(g + 6);

        // Async reset mid-session
        req = 4'b0100;
        g = cyc + 1;
        push_grant(4'b0100, 2, g);
        wait_cyc(g + 2);
        rst_n = 1'b0;
        rel_q.push_back(cyc);
        #1;
        check("rst_async_grant", {28'd0, grant}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        req = 4'b1111;
        tick(); tick();
        rst_n = 1'b1;
        g = cyc + 1;
        push_grant(4'b0001, 0, g);
        wait_cyc(g + 2);
        done = 1'b1;
        req = 4'b0;
        rel_q.push_back(g + 3);
        tick();
        done = 1'b0;
        wait_cyc(g + 7);

        check("pending_grants", gnt_q.size(), 32'd0);
        check("pending_releases", rel_q.size(), 32'd0);
        check("pending_aborts", abort_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
